// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: packs a format code, register/function fields and a
// 32-bit immediate into an RV32I instruction word. The immediate is scattered
// into I/S/B/U/J positions and range-checked. Requests that cannot be encoded
// produce NOP_WORD with out_err set.
//
// Pipeline: S1 captures the request, S2 (the output registers) holds the
// encoded word. Full valid/ready backpressure with no bubble. The pipeline
// holds at most two entries.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    request handshake
//   fmt                  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, rd, rs1, rs2, funct3, funct7, imm  request fields
//   out_valid/out_ready  result handshake
//   out_instr, out_err   encoded word and un-encodable flag
//   enc_count, err_count words delivered without and with error (wrapping)
module instr_imm_encoder #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // S1 request registers
  logic        r_s1_valid;
  logic [2:0]  r_fmt;
  logic [6:0]  r_opcode;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [31:0] r_imm;

  logic        w_s2_free;
  logic        w_accept;
  logic [31:0] w_raw;
  logic        w_ok;
  logic [31:0] w_instr;
  logic        w_hi11_eq;
  logic        w_hi12_eq;
  logic        w_hi20_eq;

  // Handshake: output slot is free when empty or draining this cycle
  assign w_s2_free = !out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;

  // S1 capture; the entry leaves S1 whenever the output slot is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_fmt      <= 3'd0;
      r_opcode   <= 7'd0;
      r_rd       <= 5'd0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_funct3   <= 3'd0;
      r_funct7   <= 7'd0;
      r_imm      <= 32'd0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_fmt      <= fmt;
      r_opcode   <= opcode;
      r_rd       <= rd;
      r_rs1      <= rs1;
      r_rs2      <= rs2;
      r_funct3   <= funct3;
      r_funct7   <= funct7;
      r_imm      <= imm;
    end else if (w_s2_free) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Sign-extension checks: the upper bits must all replicate the sign bit
  assign w_hi11_eq = (&r_imm[31:11]) || !(|r_imm[31:11]);
  assign w_hi12_eq = (&r_imm[31:12]) || !(|r_imm[31:12]);
  assign w_hi20_eq = (&r_imm[31:20]) || !(|r_imm[31:20]);

  // Field scatter and range check per format
  always_comb begin
    w_raw = NOP_WORD;
    w_ok  = 1'b0;
    case (r_fmt)
      FMT_R: begin
        w_raw = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
        w_ok  = 1'b1;
      end
      FMT_I: begin
        w_raw = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
        w_ok  = w_hi11_eq;
      end
      FMT_S: begin
        w_raw = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
        w_ok  = w_hi11_eq;
      end
      FMT_B: begin
        w_raw = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                 r_imm[4:1], r_imm[11], r_opcode};
        w_ok  = !r_imm[0] && w_hi12_eq;
      end
      FMT_U: begin
        w_raw = {r_imm[31:12], r_rd, r_opcode};
        w_ok  = (r_imm[11:0] == 12'd0);
      end
      FMT_J: begin
        w_raw = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12],
                 r_rd, r_opcode};
        w_ok  = !r_imm[0] && w_hi20_eq;
      end
      default: begin
        w_raw = NOP_WORD;
        w_ok  = 1'b0;
      end
    endcase
    w_instr = w_ok ? w_raw : NOP_WORD;
  end

  // S2 output registers; frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
    end else if (w_s2_free) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_instr <= w_instr;
        out_err   <= !w_ok;
      end
    end
  end

  // Delivery counters, advanced on the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_valid && out_ready) begin
      if (out_err) begin
        err_count <= err_count + CNT_W'(1);
      end else begin
        enc_count <= enc_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/instr_imm_encoder.md
Name: instr_imm_encoder

Overview:
- Inverse of the immediate decode path: packs a format code, register/function fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Scatters the immediate bits into I/S/B/U/J positions and range-checks the immediate against what each format can represent.
- Used by the debug/program loader and the self-test instruction generator to build instructions for instruction memory.
- Two-stage valid/ready pipeline with full backpressure, plus encoded-instruction and error counters.

Parameters:
- CNT_W, 16, width of enc_count and err_count.
- NOP_WORD, 32'h0000_0013, word emitted in place of an un-encodable request (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  input  7  instr[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  function field 3.
- funct7  input  7  function field 7 (R only).
- imm  input  32  immediate in byte-offset / sign-extended form, exactly as the decoder produces it.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts the word.
- out_instr  output  32  encoded instruction.
- out_err  output  1  request was un-encodable; out_instr is NOP_WORD.
- enc_count  output  CNT_W  words delivered with out_err=0.
- err_count  output  CNT_W  words delivered with out_err=1.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids=0, out_valid=0, out_instr=0, out_err=0, counters=0. in_ready=1 in the first cycle after reset deasserts. A request in flight during reset is discarded and never delivered.
- Stage 1 (S1): on in_valid&&in_ready, register all inputs into S1.
- Stage 2 (S2): encoding plus range check computed from S1 and registered into the output registers.
- Latency: a word accepted at edge N gives out_valid=1 after edge N+1 when the pipeline is not stalled.
- Ready logic:
  - s2_free = !out_valid || out_ready.
  - S1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational, no bubble).
  - Throughput is one word per cycle under continuous out_ready=1. With out_ready=0 the pipeline holds two entries, then in_ready=0.
- Ordering: strictly FIFO. Output registers stay stable while out_valid && !out_ready.
- Encodings:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range check (error when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0.
  - fmt 6/7: always an error.
  - Opcode is not checked against fmt.
- On error: out_instr=NOP_WORD, out_err=1. Processing continues; there is no sticky state.
- Counters:
  - Increment on the output handshake (out_valid&&out_ready): enc_count when out_err=0, err_count when out_err=1.
  - Wrap modulo 2^CNT_W.
  - Both update in the same cycle as the handshake and are visible the next cycle.
- Simultaneous in/out handshake with the pipeline full: both occur; occupancy is unchanged.

Test Plan:
- I: fmt=1, opcode=7'h13, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF -> after 2 edges out_instr=32'hFFF0_0093, out_err=0; enc_count=1 after handshake.
- B and S back-to-back, out_ready=1:
  - B: opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=32'hFFFF_FFFC -> 32'hFE20_8EE3.
  - S: opcode=7'h23, rs1=1, rs2=2, funct3=2, imm=8 -> 32'h0020_A423.
  - Both delivered on consecutive cycles, in order.
- J: opcode=7'h6F, rd=1, imm=8 -> 32'h0080_00EF. Then J with imm=9 -> 32'h0000_0013, out_err=1, err_count=1.
- U: imm=32'h1234_5001 -> out_err=1, out_instr=NOP_WORD. U: opcode=7'h37, rd=5, imm=32'h1234_5000 -> 32'h1234_52B7.
- Backpressure:
  - Hold out_ready=0 and drive 3 valid requests.
  - Required: first two accepted, in_ready=0 for the third, out_instr frozen on the first word.
  - Release out_ready: all three delivered in order, no loss or duplication.
- Reset mid-flight: two words in the pipeline, pull rst_n low asynchronously (between clock edges) -> out_valid=0 and counters=0 immediately. After release nothing stale is emitted and in_ready=1.
